// File: rtl/muldiv_scheduler.sv
// Issue/writeback scheduler for a fixed-latency multiplier and an iterative divider.
// Optional feature macro: DIV_ZERO_BYPASS_EN (divide-by-zero resolved without the divider).
module muldiv_scheduler #(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 3,
    parameter int TAG_W       = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    input  logic             req_is_div_i,
    input  logic [1:0]       req_op_i,
    input  logic [XLEN-1:0]  req_rs1_i,
    input  logic [XLEN-1:0]  req_rs2_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             req_ready_o,
    output logic [XLEN-1:0]  op_a_o,
    output logic [XLEN-1:0]  op_b_o,
    output logic             mul_start_o,
    output logic             div_start_o,
    output logic [1:0]       fu_op_o,
    input  logic             mul_valid_i,
    input  logic [XLEN-1:0]  mul_result_i,
    input  logic             div_done_i,
    input  logic [XLEN-1:0]  div_result_i,
    output logic             wb_valid_o,
    output logic [XLEN-1:0]  wb_data_o,
    output logic [TAG_W-1:0] wb_tag_o,
    input  logic             wb_ready_i,
    output logic             div_state_o
);
    localparam int DEPTH = MUL_LATENCY + 1;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {MUL_ = 2'd0, MULH_ = 2'd1, MULHSU_ = 2'd2, MULHU_ = 2'd3} mul_ops_e;
    typedef enum logic [1:0] {DIV_ = 2'd0, DIVU_ = 2'd1, REM_ = 2'd2, REMU_ = 2'd3} div_ops_e;
    typedef enum logic {FREE = 1'b0, BUSY = 1'b1} fu_state_e;
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_fsm_e;

    div_fsm_e state, state_nxt;

    logic [MUL_LATENCY:0]            vld_pipe;
    logic [MUL_LATENCY:0][TAG_W-1:0] tag_pipe;
    logic [DEPTH-1:0][XLEN-1:0]      fifo_data;
    logic [DEPTH-1:0][TAG_W-1:0]     fifo_tag;
    logic [PW-1:0]                   wr_ptr, rd_ptr;
    logic [CW-1:0]                   count, inflight, credit;
    logic [XLEN-1:0]                 div_res, bypass_val;
    logic [TAG_W-1:0]                div_tag;
    logic                            hold_mul, sel_div, fifo_empty;
    logic                            accept, mul_acc, div_acc, bypass;
    logic                            push, pop, wb_fire;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= MUL_LATENCY; i++) inflight = inflight + CW'(vld_pipe[i]);
    end

    // Slots not yet spoken for: FIFO entries plus results still in the multiplier.
    assign credit      = CW'(DEPTH) - count - inflight;
    assign req_ready_o = req_is_div_i ? (state == S_IDLE) : (credit != '0);
    assign accept      = req_valid_i & req_ready_o;
    assign mul_acc     = accept & ~req_is_div_i;
    assign div_acc     = accept & req_is_div_i;

`ifdef DIV_ZERO_BYPASS_EN
    assign bypass     = div_acc && (req_rs2_i == '0);
    assign bypass_val = (req_op_i == REM_ || req_op_i == REMU_) ? req_rs1_i : '1;
`else
    assign bypass     = 1'b0;
    assign bypass_val = '0;
`endif

    assign fifo_empty = (count == '0);
    // Once a MUL head is shown under backpressure it stays selected until taken.
    assign sel_div    = (state == S_DONE) & ~hold_mul;
    assign wb_valid_o = (state == S_DONE) | ~fifo_empty;
    assign wb_data_o  = sel_div ? div_res : (fifo_empty ? '0 : fifo_data[rd_ptr]);
    assign wb_tag_o   = sel_div ? div_tag : (fifo_empty ? '0 : fifo_tag[rd_ptr]);
    assign wb_fire    = wb_valid_o & wb_ready_i;
    assign pop        = wb_fire & ~sel_div;
    assign push       = vld_pipe[MUL_LATENCY] & mul_valid_i;

    assign mul_start_o = vld_pipe[0];
    assign div_state_o = (state == S_IDLE) ? FREE : BUSY;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (div_acc) state_nxt = bypass ? S_DONE : S_BUSY;
            S_BUSY:  if (div_done_i) state_nxt = S_DONE;
            S_DONE:  if (wb_fire && sel_div) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_pipe    <= '0;
            tag_pipe    <= '0;
            fifo_data   <= '0;
            fifo_tag    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            op_a_o      <= '0;
            op_b_o      <= '0;
            fu_op_o     <= '0;
            div_start_o <= 1'b0;
            div_res     <= '0;
            div_tag     <= '0;
            hold_mul    <= 1'b0;
        end else begin
            vld_pipe    <= {vld_pipe[MUL_LATENCY-1:0], mul_acc};
            tag_pipe    <= {tag_pipe[MUL_LATENCY-1:0], req_tag_i};
            div_start_o <= div_acc & ~bypass;
            hold_mul    <= wb_valid_o & ~wb_ready_i & ~sel_div;
            if (accept) begin
                op_a_o  <= req_rs1_i;
                op_b_o  <= req_rs2_i;
                fu_op_o <= req_op_i;
            end
            if (div_acc) begin
                div_tag <= req_tag_i;
                if (bypass) div_res <= bypass_val;
            end
            if (state == S_BUSY && div_done_i) div_res <= div_result_i;
            if (push) begin
                fifo_data[wr_ptr] <= mul_result_i;
                fifo_tag[wr_ptr]  <= tag_pipe[MUL_LATENCY];
                wr_ptr            <= inc(wr_ptr);
            end
            if (pop) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_muldiv_scheduler.sv
// Directed bench with a writeback scoreboard; behavioural MUL/DIV units drive the results.
module tb_muldiv_scheduler;
    localparam int L = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_is_div = 1'b0;
    logic [1:0]  req_op = '0;
    logic [31:0] req_rs1 = '0, req_rs2 = '0;
    logic [4:0]  req_tag = '0;
    logic        req_ready;
    logic [31:0] op_a, op_b;
    logic        mul_start, div_start;
    logic [1:0]  fu_op;
    logic        mul_valid = 1'b0;
    logic [31:0] mul_result = '0;
    logic        div_done = 1'b0;
    logic [31:0] div_result = '0;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_tag;
    logic        wb_ready = 1'b1;
    logic        div_state;

    muldiv_scheduler #(.XLEN(32), .MUL_LATENCY(L), .TAG_W(5)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_is_div_i(req_is_div),
        .req_op_i(req_op), .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_tag_i(req_tag),
        .req_ready_o(req_ready), .op_a_o(op_a), .op_b_o(op_b), .mul_start_o(mul_start),
        .div_start_o(div_start), .fu_op_o(fu_op), .mul_valid_i(mul_valid),
        .mul_result_i(mul_result), .div_done_i(div_done), .div_result_i(div_result),
        .wb_valid_o(wb_valid), .wb_data_o(wb_data), .wb_tag_o(wb_tag),
        .wb_ready_i(wb_ready), .div_state_o(div_state)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [4:0] tag; logic [31:0] data; } exp_t;
    exp_t q[$];
    int n_cmp = 0, n_bad = 0, dstarts = 0, div_lat = 4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] div_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        case (op)
            2'd0:    return $signed(a) / $signed(b);
            2'd1:    return a / b;
            2'd2:    return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    // Multiplier model: result appears L cycles after the start pulse.
    logic [32:0] dl [0:L] = '{default: '0};
    always @(negedge clk) begin
        for (int i = L; i > 0; i--) dl[i] = dl[i-1];
        dl[0] = {mul_start, op_a * op_b};
        mul_valid  = dl[L][32];
        mul_result = dl[L][31:0];
    end

    // Divider model: keeps running across a scheduler reset, like real hardware would.
    int          dcnt = 0;
    logic [31:0] dres = '0;
    always @(negedge clk) begin
        div_done = 1'b0;
        if (dcnt != 0) begin
            dcnt--;
            if (dcnt == 0) begin
                div_done   = 1'b1;
                div_result = dres;
            end
        end
        if (div_start) begin
            dstarts++;
            dcnt = div_lat;
            dres = div_model(fu_op, op_a, op_b);
        end
    end

    // Monitor: pop on handshake, and check data/tag stay put while stalled.
    logic        held = 1'b0;
    logic [36:0] held_val = '0;
    always @(negedge clk) begin
        if (rst) held = 1'b0;
        else if (wb_valid && wb_ready) begin
            held = 1'b0;
            if (q.size() == 0) check("wb_unexpected", {27'd0, wb_tag}, 32'h0);
            else begin
                exp_t e;
                e = q.pop_front();
                check("wb_tag", {27'd0, wb_tag}, {27'd0, e.tag});
                check("wb_data", wb_data, e.data);
            end
        end else if (wb_valid) begin
            if (held) check("wb_stable", {27'd0, wb_tag} ^ wb_data, {27'd0, held_val[36:32]} ^ held_val[31:0]);
            held     = 1'b1;
            held_val = {wb_tag, wb_data};
        end else held = 1'b0;
    end

    task automatic issue(input logic d, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] t);
        bit ok = 0;
        req_valid = 1'b1; req_is_div = d; req_op = op; req_rs1 = a; req_rs2 = b; req_tag = t;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (!ok) check("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        check("drain_left", q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int n, acc;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_div_state", {31'd0, div_state}, 32'd0);
        check("rst_starts", {30'd0, mul_start, div_start}, 32'd0);
        check("rst_op_a", op_a, 32'd0);
        check("rst_mul_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;

        // Single MUL: result handshake 4 cycles after the start pulse.
        q.push_back('{5'd20, 32'd12});
        issue(1'b0, 2'd0, 32'd3, 32'd4, 5'd20);
        @(negedge clk);
        check("mul_start_pulse", {31'd0, mul_start}, 32'd1);
        n = 0;
        while (!wb_valid && n < 20) begin @(negedge clk); n++; end
        check("mul_latency", n, L + 1);
        drain();

        // Back-to-back MUL stream, tags 1..8.
        for (int i = 1; i <= 8; i++) begin
            q.push_back('{5'(i), 32'(i * 11) * 32'(i + 2)});
            issue(1'b0, 2'd0, 32'(i * 11), 32'(i + 2), 5'(i));
        end
        drain();

        // Backpressure: only FIFO-depth MULs get in.
        wb_ready = 1'b0; acc = 0;
        req_valid = 1'b1; req_is_div = 1'b0; req_op = 2'd0;
        req_rs1 = 32'd2; req_rs2 = 32'd3; req_tag = 5'd21;
        for (int c = 0; c < 12; c++) begin
            bit took;
            @(negedge clk);
            took = req_ready;
            if (took) q.push_back('{5'(21 + acc), 32'(acc + 2) * 32'd3});
            @(posedge clk); #1;
            if (took) begin
                acc++;
                req_rs1 = 32'(acc + 2); req_tag = 5'(21 + acc);
            end
        end
        check("bp_accepts", acc, 4);
        @(negedge clk);
        check("bp_ready_low", {31'd0, req_ready}, 32'd0);
        check("bp_wb_valid", {31'd0, wb_valid}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; wb_ready = 1'b1;
        drain();
        @(negedge clk);
        check("bp_ready_back", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;

        // Collision: DIV done first, MUL head arrives, both pending -> DIV wins.
        wb_ready = 1'b0; div_lat = 2;
        q.push_back('{5'd9, 32'd14});
        q.push_back('{5'd3, 32'd42});
        issue(1'b1, 2'd1, 32'd100, 32'd7, 5'd9);
        issue(1'b0, 2'd0, 32'd6, 32'd7, 5'd3);
        repeat (12) @(negedge clk);
        check("coll_pending_tag", {27'd0, wb_tag}, 32'd9);
        @(posedge clk); #1 wb_ready = 1'b1;
        @(negedge clk);
        check("coll_first", {27'd0, wb_tag}, 32'd9);
        @(negedge clk);
        check("coll_second", {27'd0, wb_tag}, 32'd3);
        drain();

        // MUL head shown under backpressure stays selected when DIV completes.
        wb_ready = 1'b0; div_lat = 8;
        q.push_back('{5'd4, 32'd45});
        q.push_back('{5'd11, 32'd2});
        issue(1'b0, 2'd0, 32'd5, 32'd9, 5'd4);
        issue(1'b1, 2'd3, 32'd100, 32'd7, 5'd11);
        repeat (16) @(negedge clk);
        check("hold_div_done", {31'd0, div_state}, 32'd1);
        check("hold_mul_tag", {27'd0, wb_tag}, 32'd4);
        @(posedge clk); #1 wb_ready = 1'b1;
        @(negedge clk);
        check("hold_first", {27'd0, wb_tag}, 32'd4);
        @(negedge clk);
        check("hold_second", {27'd0, wb_tag}, 32'd11);
        drain();

        // Second DIV blocked while BUSY; a MUL overtakes it.
        div_lat = 10;
        q.push_back('{5'd13, 32'd56});
        q.push_back('{5'd12, 32'd10});
        issue(1'b1, 2'd0, 32'd50, 32'd5, 5'd12);
        req_valid = 1'b1; req_is_div = 1'b1; req_tag = 5'd14;
        @(negedge clk);
        check("busy_div_ready", {31'd0, req_ready}, 32'd0);
        check("busy_state", {31'd0, div_state}, 32'd1);
        @(posedge clk); #1 req_valid = 1'b0;
        issue(1'b0, 2'd0, 32'd7, 32'd8, 5'd13);
        drain();

        // Reset in the middle of a DIV; its late completion must be dropped.
        div_lat = 6;
        issue(1'b1, 2'd1, 32'd9, 32'd3, 5'd15);
        repeat (2) @(negedge clk);
        check("pre_rst_busy", {31'd0, div_state}, 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_state", {31'd0, div_state}, 32'd0);
        check("rst_mid_wb", {31'd0, wb_valid}, 32'd0);
        repeat (10) @(negedge clk);
        check("rst_late_done_wb", {31'd0, wb_valid}, 32'd0);
        check("rst_late_done_state", {31'd0, div_state}, 32'd0);
        @(posedge clk); #1;

        // Divide by zero.
        div_lat = 3; n = dstarts;
        q.push_back('{5'd16, 32'hFFFF_FFFF});
        issue(1'b1, 2'd0, 32'd7, 32'd0, 5'd16);
        drain();
        q.push_back('{5'd17, 32'd7});
        issue(1'b1, 2'd2, 32'd7, 32'd0, 5'd17);
        drain();
`ifdef DIV_ZERO_BYPASS_EN
        check("dz_no_start", dstarts - n, 0);
`else
        check("dz_starts", dstarts - n, 2);
`endif
        check("final_queue", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule

// File: doc/muldiv_scheduler.md
MULDIV_SCHEDULER -- requirements
Module: muldiv_scheduler

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter MUL_LATENCY, default 3, fixed cycles from mul_start_o to mul_valid_i (1..8).
REQ-003 SHALL have parameter TAG_W, default 5, destination-register tag width.
REQ-004 SHALL have ports, in order:
  - clk_i  in  1  sole clock, rising edge.
  - rst_i  in  1  synchronous, active-high reset.
  - req_valid_i  in  1  issue request valid.
  - req_is_div_i  in  1  1 = DIV unit (div_ops_e), 0 = MUL unit (mul_ops_e).
  - req_op_i  in  2  mul_ops_e/div_ops_e encoding.
  - req_rs1_i, req_rs2_i  in  XLEN  operands.
  - req_tag_i  in  TAG_W  destination tag.
  - req_ready_o  out  1  request accepted when valid&ready.
  - op_a_o, op_b_o  out  XLEN  registered operands to both units.
  - mul_start_o, div_start_o  out  1  one-cycle start pulses.
  - fu_op_o  out  2  registered op to started unit.
  - mul_valid_i  in  1, mul_result_i  in  XLEN  MUL result.
  - div_done_i  in  1, div_result_i  in  XLEN  DIV result.
  - wb_valid_o  out  1, wb_data_o  out  XLEN, wb_tag_o  out  TAG_W  writeback.
  - wb_ready_i  in  1  writeback consumer ready.
  - div_state_o  out  1  fu_state_e: FREE in IDLE, BUSY otherwise.

Function
REQ-005 SHALL issue at most one request per cycle; start pulse and operands registered, asserted the cycle after acceptance.
REQ-006 SHALL keep MUL tag pipeline of MUL_LATENCY+1 stages (valid+tag), advancing every cycle, never stalling.
REQ-007 SHALL push {mul_result_i, tag} into MUL result FIFO, depth MUL_LATENCY+1, when the final stage valid is set; mul_valid_i without matching stage ignored.
REQ-008 SHALL keep credit count = FIFO depth - FIFO occupancy - MUL ops in flight; MUL request ready iff credit > 0 (registered occupancy; pop frees a slot next cycle).
REQ-009 SHALL implement DIV FSM IDLE/BUSY/DONE: IDLE->BUSY on DIV accept; BUSY->DONE on div_done_i, capturing result and stored tag; DONE->IDLE on writeback handshake.
REQ-010 SHALL assert DIV ready only in IDLE (no accept in DONE->IDLE cycle); div_done_i outside BUSY ignored.
REQ-011 SHALL drive req_ready_o combinationally from req_is_div_i and REQ-008/REQ-010.
REQ-012 SHALL arbitrate writeback: DIV DONE has priority over MUL FIFO head; wb_valid_o = DONE | FIFO non-empty.
REQ-013 SHALL hold wb_data_o/wb_tag_o stable while wb_valid_o=1 and wb_ready_i=0; selection only changes after handshake.
REQ-014 SHALL allow FIFO push and pop in the same cycle, occupancy unchanged.
REQ-015 SHALL deliver MUL result in order of issue; MUL results may overtake a BUSY DIV.

Reset
REQ-016 SHALL on rst_i=1 at clock edge: FSM IDLE, tag pipeline and FIFO cleared, credit = depth, all outputs 0 (div_state_o FREE), regardless of operation in progress.
REQ-017 SHALL ignore unit results arriving after reset for pre-reset operations.

Configuration
REQ-018 SHALL with DIV_ZERO_BYPASS_EN defined: DIV accept with req_rs2_i=0 not pulse div_start_o, FSM IDLE->DONE next cycle, result all-ones for DIV_/DIVU_, req_rs1_i for REM_/REMU_.
REQ-019 SHALL without DIV_ZERO_BYPASS_EN: divide-by-zero handled as any DIV request through divider.

Verification
REQ-020 Reset: rst_i=1 mid-DIV BUSY -> next cycle div_state_o=FREE, wb_valid_o=0, later div_done_i ignored.
REQ-021 MUL stream: 8 back-to-back MUL, tags 1..8, wb_ready_i=1 -> wb_tag_o 1..8 in order, first 4 cycles after issue.
REQ-022 Backpressure: wb_ready_i=0, MUL requests held -> exactly 4 accepted, then req_ready_o=0 until pops.
REQ-023 Collision: DIV DONE tag 9 and MUL head tag 3 same cycle -> tag 9 written first, tag 3 next cycle.
REQ-024 DIV busy: second DIV while BUSY -> req_ready_o=0; MUL accepted meanwhile.
REQ-025 Bypass (macro on): DIV_ 7/0 -> no div_start_o, wb_data_o=32'hFFFFFFFF; REM_ 7/0 -> wb_data_o=7.
